// File: rtl/pulse_stretch_multi.sv
// Multi-channel pulse stretcher: each channel turns a level or rising-edge trigger
// into a pulse of a runtime-programmable length, with optional retrigger and abort.
module pulse_stretch_multi #(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 8,
    parameter int RETRIG = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    edge_mode,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*LEN_W-1:0] len,
    input  logic [NUM_CH-1:0]       abort,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       done,
    output logic                    busy
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [NUM_CH-1:0] r_trig_q;
    logic [NUM_CH-1:0] r_done;
    logic              r_busy;
    logic [NUM_CH-1:0] w_done_next;
    logic [NUM_CH-1:0] w_pulse;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           r_state;
            state_t           w_state_next;
            logic [LEN_W-1:0] r_cnt;
            logic [LEN_W-1:0] w_cnt_next;
            logic [LEN_W-1:0] r_len_q;
            logic [LEN_W-1:0] w_len_q_next;
            logic [LEN_W-1:0] w_len;
            logic             w_ev;
            logic             w_len_zero;
            logic             w_len_one;
            logic             w_last;
            logic             w_done_nx;
            logic             w_pulse_ch;

            assign w_len      = len[gi*LEN_W +: LEN_W];
            assign w_ev       = edge_mode ? (trig[gi] & ~r_trig_q[gi]) : trig[gi];
            assign w_len_zero = (w_len == LEN_ZERO);
            assign w_len_one  = (w_len == LEN_ONE);
            assign w_last     = (r_cnt == (r_len_q - LEN_ONE));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_len_q <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_len_q <= w_len_q_next;
                end
            end

            // Abort outranks everything, including an event in the same cycle.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_len_q_next = r_len_q;
                w_done_nx    = 1'b0;
                if (abort[gi]) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_ev && !w_len_zero) begin
                                w_len_q_next = w_len;
                                if (w_len_one) begin
                                    w_done_nx = 1'b1;
                                end else begin
                                    w_cnt_next   = LEN_ONE;
                                    w_state_next = S_ACTIVE;
                                end
                            end
                        end
                        S_ACTIVE: begin
                            if ((RETRIG != 0) && w_ev && !w_len_zero) begin
                                w_len_q_next = w_len;
                                if (w_len_one) begin
                                    w_state_next = S_IDLE;
                                    w_cnt_next   = '0;
                                    w_done_nx    = 1'b1;
                                end else begin
                                    w_cnt_next = LEN_ONE;
                                end
                            end else if (w_last) begin
                                w_state_next = S_IDLE;
                                w_cnt_next   = '0;
                                w_done_nx    = 1'b1;
                            end else begin
                                w_cnt_next = r_cnt + LEN_ONE;
                            end
                        end
                        default: begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end
                    endcase
                end
            end

            // The starting cycle is high combinationally, before the state register moves.
            always_comb begin
                w_pulse_ch = 1'b0;
                if (!rst && !abort[gi]) begin
                    w_pulse_ch = (r_state == S_ACTIVE) || (w_ev && !w_len_zero);
                end
            end

            assign w_done_next[gi] = w_done_nx;
            assign w_pulse[gi]     = w_pulse_ch;
        end
    endgenerate

    // busy lags the pulse by one cycle, so it covers the starting cycle too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_q <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_trig_q <= trig;
            r_done   <= w_done_next;
            r_busy   <= |w_pulse;
        end
    end

    assign pulse_out = w_pulse;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule
